// File: rtl/fir_pkg.sv
// Shared types and constants for the decimating FIR stage.
package fir_pkg;

  localparam int unsigned PkgWidth = 32;
  localparam int unsigned PkgFrac  = 10;
  localparam int unsigned MaxTaps  = 20;

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_WRITE} state_t;

  // Integer value to fixed point with PkgFrac fraction bits.
  function automatic logic signed [PkgWidth-1:0] QUANT_VAL(input int v);
    logic signed [PkgWidth-1:0] r;
    r = PkgWidth'(v);
    return r <<< PkgFrac;
  endfunction

  // Drop fraction bits of a full-width accumulator, rounding toward -inf.
  function automatic logic signed [2*PkgWidth-1:0] DEQUANTIZE(
    input logic signed [2*PkgWidth-1:0] a
  );
    return a >>> PkgFrac;
  endfunction

  localparam logic signed [PkgWidth-1:0] COEFFS [MaxTaps] = '{
    QUANT_VAL(1),  QUANT_VAL(2),  QUANT_VAL(3),  QUANT_VAL(4),  QUANT_VAL(5),
    QUANT_VAL(6),  QUANT_VAL(7),  QUANT_VAL(8),  QUANT_VAL(9),  QUANT_VAL(10),
    QUANT_VAL(11), QUANT_VAL(12), QUANT_VAL(13), QUANT_VAL(14), QUANT_VAL(15),
    QUANT_VAL(16), QUANT_VAL(17), QUANT_VAL(18), QUANT_VAL(19), QUANT_VAL(20)
  };

endpackage

// File: rtl/fir_mac.sv
// Time-shared multiply-accumulate with dequantize output path.
// Build option: define FIR_SATURATE_EN to clamp the result instead of wrapping.
module fir_mac #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned AccW = 2 * DATA_WIDTH;

  logic signed [AccW-1:0] acc_q, acc_d, prod;

  // Full-width signed product and wrapping accumulator update.
  always_comb begin
    prod  = $signed({{DATA_WIDTH{x[DATA_WIDTH-1]}}, x}) *
            $signed({{DATA_WIDTH{c[DATA_WIDTH-1]}}, c});
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + prod;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef FIR_SATURATE_EN
  localparam logic signed [AccW-1:0] SatMax = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [AccW-1:0] shifted;

  // Shift out the fraction, then clamp to the output range.
  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    if (shifted > SatMax) begin
      result = SatMax[DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      result = SatMin[DATA_WIDTH-1:0];
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
  end
`else
  // Shift out the fraction and keep the low bits (wraps).
  always_comb begin
    result = acc_q[FRAC_BITS +: DATA_WIDTH];
  end
`endif

endmodule

// File: rtl/fir_decim.sv
// Decimating FIR stage between an FWFT upstream FIFO and a downstream FIFO.
// Build option: FIR_SATURATE_EN (see fir_mac) selects saturating output.
module fir_decim
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_TAPS   = 20,
  parameter int unsigned DECIMATION = 1,
  parameter int unsigned FRAC_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int unsigned TapW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned DecW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] x_d [NUM_TAPS];
  logic [TapW-1:0]       tap_q, tap_d;
  logic [DecW-1:0]       dec_q, dec_d;
  logic                  mac_clr, mac_en;
  logic [DATA_WIDTH-1:0] mac_x, mac_c;

  // Next-state, shift register and FIFO handshakes.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    tap_d     = tap_q;
    dec_d     = dec_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        // Keep the FIFO from popping while this stage is held in reset.
        in_rd_en = reset_n && !in_empty;
        if (!in_empty) begin
          x_d[0] = in_dout;
          for (int i = 1; i < int'(NUM_TAPS); i++) begin
            x_d[i] = x_q[i-1];
          end
          if (dec_q == DecW'(DECIMATION - 1)) begin
            dec_d   = '0;
            tap_d   = '0;
            mac_clr = 1'b1;
            state_d = S_MAC;
          end else begin
            dec_d = dec_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (tap_q == TapW'(NUM_TAPS - 1)) begin
          state_d = S_WRITE;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_WRITE: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          dec_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, history and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      x_q     <= '{default: '0};
      tap_q   <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tap_q   <= tap_d;
      dec_q   <= dec_d;
    end
  end

  // Operand select for the shared multiplier.
  always_comb begin
    mac_x = x_q[tap_q];
    mac_c = DATA_WIDTH'(COEFFS[tap_q]);
  end

  fir_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (mac_clr),
    .acc_en (mac_en),
    .x      (mac_x),
    .c      (mac_c),
    .result (out_din)
  );

endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: DECIMATION=1 and DECIMATION=4 instances behind one FIFO model.
module tb_fir_decim;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        out_full = 1'b0;
  logic        starve_en = 1'b0;
  logic        starve_ph;
  logic        src_empty;
  logic [31:0] in_dout;
  logic        in_empty_a, in_empty_b, rd_en_a, rd_en_b, full_a, full_b, wr_a, wr_b;
  logic [31:0] din_a, din_b;
  logic        rd_en, wr_en, will_pop;
  logic [31:0] din;

  logic [31:0] src_q[$];
  logic [31:0] out_q[$];
  int          out_cyc[$];
  int          pop_cyc[$];
  int          cycle = 0;
  int          pops = 0;
  int          rd_viol = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  assign in_empty_a = sel ? 1'b1 : src_empty;
  assign in_empty_b = sel ? src_empty : 1'b1;
  assign full_a     = sel ? 1'b0 : out_full;
  assign full_b     = sel ? out_full : 1'b0;
  assign rd_en      = sel ? rd_en_b : rd_en_a;
  assign wr_en      = sel ? wr_b : wr_a;
  assign din        = sel ? din_b : din_a;

  fir_decim #(.DATA_WIDTH(32), .NUM_TAPS(20), .DECIMATION(1), .FRAC_BITS(10)) dut (
    .clk(clk), .reset_n(reset_n), .in_dout(in_dout), .in_empty(in_empty_a), .in_rd_en(rd_en_a),
    .out_full(full_a), .out_wr_en(wr_a), .out_din(din_a)
  );

  fir_decim #(.DATA_WIDTH(32), .NUM_TAPS(20), .DECIMATION(4), .FRAC_BITS(10)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_dout(in_dout), .in_empty(in_empty_b), .in_rd_en(rd_en_b),
    .out_full(full_b), .out_wr_en(wr_b), .out_din(din_b)
  );

  // FWFT upstream FIFO model and downstream capture; samples mid-cycle, updates after the edge.
  initial begin
    src_empty = 1'b1;
    in_dout   = '0;
    starve_ph = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rd_en && src_empty) rd_viol++;
      will_pop = rd_en && !src_empty;
      if (will_pop) pop_cyc.push_back(cycle);
      if (wr_en) begin
        out_q.push_back(din);
        out_cyc.push_back(cycle);
      end
      @(posedge clk);
      #1;
      if (will_pop && src_q.size() > 0) begin
        void'(src_q.pop_front());
        pops++;
      end
      starve_ph = ~starve_ph;
      src_empty = (src_q.size() == 0) || (starve_en && starve_ph);
      in_dout   = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  task automatic do_reset(input logic s);
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    sel       = s;
    out_full  = 1'b0;
    starve_en = 1'b0;
    src_q.delete();
    out_q.delete();
    out_cyc.delete();
    pop_cyc.delete();
    pops = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Bounded wait for n pushes, then idle a while and require exactly n.
  task automatic wait_outs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (60) @(posedge clk);
    n_checks++;
    if (out_q.size() !== n) $display("FAIL %s push count: got %0d required %0d", name, out_q.size(), n);
    else n_pass++;
  endtask

  task automatic run_impulse(input int amp, input logic chk_lat, input string name);
    logic [31:0] got, exp;
    src_q.push_back(32'(amp));
    repeat (19) src_q.push_back(32'd0);
    wait_outs(20, 2000, name);
    for (int i = 0; i < 20; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 32'hx;
      exp = 32'((i + 1) * amp);
      n_checks++;
      if (got !== exp) $display("FAIL %s out[%0d]: got %h required %h", name, i, got, exp);
      else n_pass++;
    end
    if (chk_lat) begin
      n_checks++;
      if (out_cyc.size() < 1 || pop_cyc.size() < 1 || out_cyc[0] - pop_cyc[0] !== 21)
        $display("FAIL %s latency: got %0d required 21", name,
                 (out_cyc.size() > 0 && pop_cyc.size() > 0) ? out_cyc[0] - pop_cyc[0] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    src_q.push_back(32'd5);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en_a, wr_a, din_a, rd_en_b, wr_b, din_b} !== '0)
      $display("FAIL reset outputs: got rd=%b%b wr=%b%b din=%h/%h required all zero",
               rd_en_a, rd_en_b, wr_a, wr_b, din_a, din_b);
    else n_pass++;
    do_reset(1'b0);
  endtask

  task automatic test_impulse();
    do_reset(1'b0);
    run_impulse(1024, 1'b1, "impulse");
    do_reset(1'b0);
    run_impulse(-1024, 1'b1, "neg_impulse");
  endtask

  task automatic test_dc();
    logic [31:0] got, exp;
    do_reset(1'b0);
    repeat (40) src_q.push_back(32'd1024);
    wait_outs(40, 3000, "dc");
    for (int n = 1; n <= 40; n++) begin
      got = (n <= out_q.size()) ? out_q[n-1] : 32'hx;
      exp = (n < 20) ? 32'(n * (n + 1) / 2 * 1024) : 32'(210 * 1024);
      n_checks++;
      if (got !== exp) $display("FAIL dc out[%0d]: got %h required %h", n, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_decimation();
    logic [31:0] got, exp;
    int          m, span;
    do_reset(1'b1);
    repeat (80) src_q.push_back(32'd1024);
    wait_outs(20, 3000, "dec4");
    for (int i = 0; i < 20; i++) begin
      m   = (4 * (i + 1) < 20) ? 4 * (i + 1) : 20;
      got = (i < out_q.size()) ? out_q[i] : 32'hx;
      exp = 32'(m * (m + 1) / 2 * 1024);
      n_checks++;
      if (got !== exp) $display("FAIL dec4 out[%0d]: got %h required %h", i, got, exp);
      else n_pass++;
    end
    for (int i = 1; i < 20; i++) begin
      span = (i < out_cyc.size()) ? out_cyc[i] - out_cyc[i-1] : 0;
      n_checks++;
      if (span < 24) $display("FAIL dec4 spacing[%0d]: got %0d required >= 24", i, span);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int          bad_wr, bad_rd, bad_din, pops_held;
    logic [31:0] got, exp;
    do_reset(1'b0);
    out_full = 1'b1;
    src_q.push_back(32'd1024);
    repeat (19) src_q.push_back(32'd0);
    repeat (30) @(posedge clk);
    pops_held = pops;
    bad_wr = 0;
    bad_rd = 0;
    bad_din = 0;
    repeat (50) begin
      @(negedge clk);
      if (wr_a !== 1'b0) bad_wr++;
      if (rd_en_a !== 1'b0) bad_rd++;
      if (din_a !== 32'd1024) bad_din++;
    end
    n_checks++;
    if (bad_wr != 0) $display("FAIL bp wr_en: got %0d high cycles required 0", bad_wr);
    else n_pass++;
    n_checks++;
    if (bad_rd != 0 || pops !== pops_held)
      $display("FAIL bp rd_en: got %0d high cycles, %0d pops required 0", bad_rd, pops - pops_held);
    else n_pass++;
    n_checks++;
    if (bad_din != 0) $display("FAIL bp din stable: got %0d bad cycles required 0", bad_din);
    else n_pass++;
    @(posedge clk);
    #2;
    out_full = 1'b0;
    wait_outs(20, 2000, "bp");
    for (int i = 0; i < 20; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 32'hx;
      exp = 32'((i + 1) * 1024);
      n_checks++;
      if (got !== exp) $display("FAIL bp out[%0d]: got %h required %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_starve();
    do_reset(1'b0);
    rd_viol   = 0;
    starve_en = 1'b1;
    run_impulse(1024, 1'b0, "starve");
    n_checks++;
    if (rd_viol !== 0) $display("FAIL starve rd_en while empty: got %0d required 0", rd_viol);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int k;
    do_reset(1'b0);
    src_q.push_back(32'd1024);
    repeat (19) src_q.push_back(32'd0);
    k = 0;
    while (pops < 1 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    n_checks++;
    if (pops < 1) $display("FAIL midrst first pop: got %0d pops required 1", pops);
    else n_pass++;
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_a, rd_en_a, din_a} !== '0)
      $display("FAIL midrst outputs: got wr=%b rd=%b din=%h required zero", wr_a, rd_en_a, din_a);
    else n_pass++;
    do_reset(1'b0);
    run_impulse(1024, 1'b1, "midrst_rerun");
  endtask

  task automatic test_saturate();
    logic [31:0] exp2, exp20, got;
`ifdef FIR_SATURATE_EN
    exp2  = 32'h7FFFFFFF;
    exp20 = 32'h7FFFFFFF;
`else
    exp2  = 32'h7FFFFFFD;
    exp20 = 32'hFFFFFF2E;
`endif
    do_reset(1'b0);
    repeat (20) src_q.push_back(32'h7FFFFFFF);
    wait_outs(20, 2000, "sat");
    got = (out_q.size() > 0) ? out_q[0] : 32'hx;
    n_checks++;
    if (got !== 32'h7FFFFFFF) $display("FAIL sat out[0]: got %h required 7fffffff", got);
    else n_pass++;
    got = (out_q.size() > 1) ? out_q[1] : 32'hx;
    n_checks++;
    if (got !== exp2) $display("FAIL sat out[1]: got %h required %h", got, exp2);
    else n_pass++;
    got = (out_q.size() > 19) ? out_q[19] : 32'hx;
    n_checks++;
    if (got !== exp20) $display("FAIL sat out[19]: got %h required %h", got, exp20);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_decimation();
    test_backpressure();
    test_starve();
    test_mid_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
